// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizes a raw button, debounces it with a
// four-state qualify FSM, and emits a one-cycle strobe plus a saturating count.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    output logic       o_pulse,
    output logic       o_level,
    output logic [7:0] o_press_cnt
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESS_CHK = 2'd1,
        S_HELD      = 2'd2,
        S_REL_CHK   = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic [7:0]             press_cnt_q, press_cnt_d;

    // The first stage is the only reader of the asynchronous button.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_btn};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        pulse_d     = 1'b0;
        press_cnt_d = press_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                level_d = 1'b0;
                if (sync) begin
                    state_d = S_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            S_PRESS_CHK: begin
                if (!sync) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_HELD;
                    cnt_d       = '0;
                    level_d     = 1'b1;
                    pulse_d     = 1'b1;
                    press_cnt_d = (press_cnt_q == 8'hFF) ? press_cnt_q : press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                level_d = 1'b1;
                if (!sync) begin
                    state_d = S_REL_CHK;
                    cnt_d   = '0;
                end
            end
            S_REL_CHK: begin
                if (sync) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sync_q      <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            pulse_q     <= 1'b0;
            press_cnt_q <= 8'h00;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            pulse_q     <= pulse_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign o_pulse     = pulse_q;
    assign o_level     = level_q;
    assign o_press_cnt = press_cnt_q;

endmodule
